// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a two-entry skid buffer, flush and control-only bubble.
// Optional statistics counters (stall_cnt, flush_cnt) are enabled by defining PIPE_STATS_EN.
module pipe_stage_skid #(
    parameter int ADDR_W = 32,
    parameter int CTRL_W = 8,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [ADDR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [ADDR_W-1:0] out_instr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam int ENT_W = 2 * ADDR_W + CTRL_W + DATA_W;

    // State encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               in_ready_r;
    logic [ENT_W-1:0]   main_q_r;
    logic [ENT_W-1:0]   skid_q_r;
    logic [ENT_W-1:0]   in_ent_s;
    logic               main_v_s;
    logic               skid_v_s;
    logic               accept_s;
    logic               drain_s;
    logic               load_main_s;
    logic               load_skid_s;
    logic               move_skid_s;

    assign main_v_s = state_r[0];
    assign skid_v_s = state_r[1];
    assign accept_s = in_valid & in_ready_r & ~flush;
    assign drain_s  = main_v_s & out_ready;
    assign in_ent_s = {in_pc, in_instr, (bubble ? {CTRL_W{1'b0}} : in_ctrl), in_data};

    // State register; in_ready is registered so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            in_ready_r <= (next_state_s != SKID);
        end
    end

    // Next-state decode; flush overrides every other event.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (accept_s) next_state_s = FULL;
                    else          next_state_s = EMPTY;
                end
                FULL: begin
                    if (accept_s && !drain_s)      next_state_s = SKID;
                    else if (!accept_s && drain_s) next_state_s = EMPTY;
                    else                           next_state_s = FULL;
                end
                SKID: begin
                    if (drain_s) next_state_s = FULL;
                    else         next_state_s = SKID;
                end
                default: next_state_s = EMPTY;
            endcase
        end
    end

    // Datapath load controls derived from the current state.
    always_comb begin
        load_main_s = 1'b0;
        load_skid_s = 1'b0;
        move_skid_s = 1'b0;
        case (state_r)
            EMPTY: load_main_s = accept_s;
            FULL: begin
                if (accept_s && drain_s) begin
                    load_main_s = 1'b1;
                end else if (accept_s) begin
                    load_skid_s = 1'b1;
                end else begin
                    load_main_s = 1'b0;
                end
            end
            SKID:    move_skid_s = drain_s;
            default: load_main_s = 1'b0;
        endcase
    end

    // Payload storage; flush zeroes both entries so idle outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q_r <= {ENT_W{1'b0}};
            skid_q_r <= {ENT_W{1'b0}};
        end else if (flush) begin
            main_q_r <= {ENT_W{1'b0}};
            skid_q_r <= {ENT_W{1'b0}};
        end else begin
            if (load_main_s) begin
                main_q_r <= in_ent_s;
            end else if (move_skid_s) begin
                main_q_r <= skid_q_r;
            end else begin
                main_q_r <= main_q_r;
            end
            if (load_skid_s) begin
                skid_q_r <= in_ent_s;
            end else begin
                skid_q_r <= skid_q_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = main_v_s;
    assign out_pc    = main_q_r[ENT_W-1 -: ADDR_W];
    assign out_instr = main_q_r[ENT_W-ADDR_W-1 -: ADDR_W];
    assign out_ctrl  = main_q_r[DATA_W+CTRL_W-1 -: CTRL_W];
    assign out_data  = main_q_r[DATA_W-1:0];

`ifdef PIPE_STATS_EN
    // Saturating statistics counters, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= {CNT_W{1'b0}};
            flush_cnt <= {CNT_W{1'b0}};
        end else begin
            if (main_v_s && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt <= stall_cnt;
            end
            if (flush && (main_v_s || skid_v_s) && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                flush_cnt <= flush_cnt;
            end
        end
    end
`else
    logic unused_skid_v_s;
    assign unused_skid_v_s = skid_v_s;
`endif

endmodule
